// File: rtl/fanout_fork_driver_pkg.sv
// fanout_fork_pkg: shared types and constants for the fanout fork driver.
//   MAX_LOADS   - upper bound on the number of fork loads
//   STALL_CNT_W - width of each per-load stall counter (optional stats build)
//   count_t     - skid buffer occupancy (0, 1 or 2)
//   all_ones()  - true when the low n bits of a mask are all set
package fanout_fork_pkg;

  localparam int MAX_LOADS   = 16;
  localparam int STALL_CNT_W = 16;

  typedef logic [1:0] count_t;

  // Bits at or above n are ignored, so one function serves every NLOADS.
  function automatic logic all_ones(input logic [MAX_LOADS-1:0] mask, input int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_LOADS; i++) begin
      if ((i < n) && !mask[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fanout_fork_driver_if.sv
// fanout_fork_driver_if: upstream handshake plus the per-load fork handshake.
//   in_valid/in_ready/in_data     - one word per upstream handshake
//   out_valid/out_ready (NLOADS)  - independent per-load handshakes
//   out_data                      - word broadcast to every load
// slave is the driver stage itself; master is whatever sits around it.
interface fanout_fork_driver_if #(
  parameter int WIDTH  = 8,
  parameter int NLOADS = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [NLOADS-1:0] out_valid;
  logic [NLOADS-1:0] out_ready;
  logic [WIDTH-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fanout_fork_driver_skid2.sv
// fanout_skid2: two-entry skid buffer (head H, skid S) with valid/ready on
// both sides.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - write side; in_ready is a register (count < 2)
//   in_data             - word to store
//   out_valid/out_ready - read side; out_ready pops H
//   out_data            - H contents (0 after reset, held when empty)
//   count               - occupancy
module fanout_skid2
  import fanout_fork_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output count_t           count
);

  count_t           count_q, count_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] head_q, skid_q;
  logic             push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_ready & (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      count_q    <= count_d;
      // Registered from next-state occupancy: no path from out_ready.
      in_ready_q <= (count_d < 2'd2);
      if (pop && (count_q == 2'd2)) head_q <= skid_q;
      // A push with a pop can only happen at count 1 (full blocks push),
      // so the new word lands straight in H.
      if (push) begin
        if ((count_q == 2'd0) || pop) head_q <= in_data;
        else                          skid_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/fanout_fork_driver.sv
// fanout_fork_driver: registered driver stage broadcasting each word to
// NLOADS loads as an eager fork. A word retires only once every load took it.
//   clk, rst_n - clock, async active-low reset
//   bus        - fanout_fork_driver_if.slave (upstream + per-load handshakes)
//   busy       - skid buffer non-empty
//   stall_cnt  - NLOADS x 16-bit saturating stall counters, present only
//                when FANOUT_FORK_STATS_EN is defined
// NLOADS must lie in 1..MAX_LOADS.
module fanout_fork_driver
  import fanout_fork_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NLOADS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fanout_fork_driver_if.slave  bus,
`ifdef FANOUT_FORK_STATS_EN
  output logic [NLOADS*STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic                 busy
);

  logic              head_valid;
  logic              retire_ok;
  logic [WIDTH-1:0]  head_data;
  count_t            count;
  logic [NLOADS-1:0] done_q;
  logic [NLOADS-1:0] valid_vec;
  logic [NLOADS-1:0] fire;
  logic [NLOADS-1:0] taken;
  logic [MAX_LOADS-1:0] taken_ext;

  fanout_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (bus.in_data),
    .out_valid (head_valid),
    .out_ready (retire_ok),
    .out_data  (head_data),
    .count     (count)
  );

  assign valid_vec = {NLOADS{head_valid}} & ~done_q;
  assign fire      = valid_vec & bus.out_ready;
  assign taken     = done_q | fire;

  always_comb begin
    taken_ext             = '0;
    taken_ext[NLOADS-1:0] = taken;
  end

  // The skid buffer only pops when it actually holds a word.
  assign retire_ok = all_ones(taken_ext, NLOADS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      done_q <= '0;
    else if (head_valid && retire_ok) done_q <= '0;
    else                             done_q <= taken;
  end

  assign bus.out_valid = valid_vec;
  assign bus.out_data  = head_data;
  assign busy          = (count != 2'd0);

`ifdef FANOUT_FORK_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q [NLOADS];

  for (genvar g = 0; g < NLOADS; g++) begin : g_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stall_q[g] <= '0;
      end else if (valid_vec[g] && !bus.out_ready[g] && (stall_q[g] != '1)) begin
        stall_q[g] <= stall_q[g] + 1'b1;
      end
    end
    assign stall_cnt[g*STALL_CNT_W +: STALL_CNT_W] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_fanout_fork_driver.sv
module tb_fanout_fork_driver;

  localparam int W  = 8;
  localparam int NL = 3;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef FANOUT_FORK_STATS_EN
  logic [NL*16-1:0] stall_cnt;
`endif

  fanout_fork_driver_if #(.WIDTH(W), .NLOADS(NL)) bus ();

  fanout_fork_driver #(.WIDTH(W), .NLOADS(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef FANOUT_FORK_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: every accepted word in order, and how many words each
  // load has consumed. A word is retired once all loads consumed it.
  logic [W-1:0] hist[$];
  int           cons[NL];
  bit           m_live;

  function automatic int m_retired();
    int m;
    m = cons[0];
    for (int i = 1; i < NL; i++) if (cons[i] < m) m = cons[i];
    return m;
  endfunction

  function automatic int m_count();
    return hist.size() - m_retired();
  endfunction

  function automatic logic m_in_ready();
    return logic'(m_live && (m_count() < 2));
  endfunction

  function automatic logic [NL-1:0] m_valid();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = (m_count() > 0) && (cons[i] == m_retired());
    return v;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < NL; i++) cons[i] = 0;
    m_live = 1'b0;
  endtask

  task automatic tick();
    logic          acc;
    logic [NL-1:0] f;
    logic [W-1:0]  d;
    acc = bus.in_valid & m_in_ready();
    f   = m_valid() & bus.out_ready;
    d   = bus.in_data;
    @(posedge clk);
    if (acc) hist.push_back(d);
    for (int i = 0; i < NL; i++) if (f[i]) cons[i]++;
    if (rst_n) m_live = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 3'b111;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 3'b000) begin bad++; $display("FAIL rst_out_valid got=%b exp=000", bus.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rel_first_edge_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready_rise got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 3'b000) begin bad++; $display("FAIL rel_out_valid got=%b exp=000", bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 3'b111) begin bad++; $display("FAIL a5_out_valid got=%b exp=111", bus.out_valid); end
    total++; if (bus.out_data !== 8'hA5) begin bad++; $display("FAIL a5_out_data got=%h exp=a5", bus.out_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL a5_busy got=%b exp=1", busy); end
    tick();
    total++; if (bus.out_valid !== 3'b000) begin bad++; $display("FAIL a5_retired got=%b exp=000", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 3'b111;
    for (int w = 1; w <= 16; w++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(w);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready w=%0d got=%b exp=1", w, bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 3'b111 || bus.out_data !== W'(w))
        begin bad++; $display("FAIL b2b_word got=%b/%h exp=111/%h", bus.out_valid, bus.out_data, W'(w)); end
    end
    bus.in_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_last got=%b exp=1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_drop got=%b exp=0", busy); end
  endtask

  task automatic test_stagger();
    logic [NL-1:0] rdy [3] = '{3'b001, 3'b100, 3'b010};
    logic [NL-1:0] exp [3] = '{3'b110, 3'b010, 3'b000};
    bus.out_ready = 3'b000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 3'b111 || bus.out_data !== 8'h3C)
      begin bad++; $display("FAIL stag_start got=%b/%h exp=111/3c", bus.out_valid, bus.out_data); end
    for (int s = 0; s < 3; s++) begin
      bus.out_ready = rdy[s];
      tick();
      total++; if (bus.out_valid !== exp[s]) begin bad++; $display("FAIL stag_step%0d got=%b exp=%b", s, bus.out_valid, exp[s]); end
    end
    bus.out_ready = 3'b111;
    tick();
    total++; if (bus.out_valid !== 3'b000 || busy !== 1'b0)
      begin bad++; $display("FAIL stag_no_repeat got=%b/%b exp=000/0", bus.out_valid, busy); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] seq [3] = '{8'h11, 8'h22, 8'h33};
    bus.out_ready = 3'b000;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = seq[k];
      tick();
    end
    bus.in_data = seq[2];
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 3'b111 || bus.out_data !== 8'h11)
      begin bad++; $display("FAIL bp_hold got=%b/%h exp=111/11", bus.out_valid, bus.out_data); end
    bus.out_ready = 3'b111;
    tick();
    total++; if (bus.in_ready !== 1'b1 || bus.out_data !== 8'h22)
      begin bad++; $display("FAIL bp_drain1 got=%b/%h exp=1/22", bus.in_ready, bus.out_data); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 3'b111 || bus.out_data !== 8'h33)
      begin bad++; $display("FAIL bp_drain2 got=%b/%h exp=111/33", bus.out_valid, bus.out_data); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", busy); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 3'b000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA1;
    tick();
    bus.in_data = 8'hB2;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b010;
    tick();
    total++; if (bus.out_valid !== 3'b101 || busy !== 1'b1)
      begin bad++; $display("FAIL mid_pre got=%b/%b exp=101/1", bus.out_valid, busy); end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    total++; if (bus.out_valid !== 3'b000 || busy !== 1'b0 || bus.in_ready !== 1'b0)
      begin bad++; $display("FAIL mid_async got=%b/%b/%b exp=000/0/0", bus.out_valid, busy, bus.in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h7E;
    bus.out_ready = 3'b111;
    tick();
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 3'b111 || bus.out_data !== 8'h7E)
      begin bad++; $display("FAIL mid_new_word got=%b/%h exp=111/7e", bus.out_valid, bus.out_data); end
    tick();
    total++; if (bus.out_valid !== 3'b000 || busy !== 1'b0)
      begin bad++; $display("FAIL mid_no_stale got=%b/%b exp=000/0", bus.out_valid, busy); end
  endtask

  task automatic test_random();
    logic [NL-1:0] ev;
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_data  = W'($urandom);
      for (int i = 0; i < NL; i++) bus.out_ready[i] = ($urandom_range(0, 3) != 0);
      tick();
      ev = m_valid();
      total++; if (bus.out_valid !== ev) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, ev); end
      total++; if (bus.in_ready !== m_in_ready()) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, m_in_ready()); end
      total++; if (busy !== (m_count() > 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%0d", c, busy, m_count()); end
      if (ev != '0) begin
        total++; if (bus.out_data !== hist[m_retired()])
          begin bad++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, bus.out_data, hist[m_retired()]); end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b111;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%b exp=0", busy); end
  endtask

`ifdef FANOUT_FORK_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    model_clear();
    bus.in_valid  = 1'b0;
    bus.out_ready = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (stall_cnt !== '0) begin bad++; $display("FAIL stats_clear got=%h exp=0", stall_cnt); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    total++; if (stall_cnt !== {16'd5, 16'd5, 16'd5}) begin bad++; $display("FAIL stats_five got=%h exp=000500050005", stall_cnt); end
    bus.out_ready = 3'b101;
    repeat (70000) tick();
    total++; if (stall_cnt[31:16] !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h exp=ffff", stall_cnt[31:16]); end
    total++; if (stall_cnt[15:0] !== 16'd5 || stall_cnt[47:32] !== 16'd5)
      begin bad++; $display("FAIL stats_others got=%h/%h exp=0005/0005", stall_cnt[15:0], stall_cnt[47:32]); end
    bus.out_ready = 3'b111;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stagger();
    test_backpressure();
    test_mid_reset();
    test_random();
`ifdef FANOUT_FORK_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
